vcfg_unit: RTL and testbench

- Responder side of the RVV configuration protocol.
- Executes vsetvli, vsetivli and vsetvl instructions issued by the scalar core, computes the new vl and vtype, and holds the vl, vtype and vstart CSR state.
- Returns the new vl as the rd result to the core through a valid/ready pipeline (2-cycle latency, 1 instruction/cycle throughput).
- Sits between the CVA6 accelerator dispatch port and the Ara dispatcher, which consume vl_o, vtype_o and vstart_o.

---
 rtl/rvv_pkg.sv | 96 +++++++++
 rtl/vcfg_vl_calc.sv | 35 +++
 rtl/vcfg_unit.sv | 137 +++++++++++++
 tb/tb_vcfg_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared RVV types: vtype encoding, vset* instruction formats and vector configuration helpers.
package rvv_pkg;

  localparam int unsigned RvXlen = 64;

  localparam logic [6:0] OpcodeVec = 7'h57;
  localparam logic [2:0] OPIVV     = 3'b000;
  localparam logic [2:0] OPCFG     = 3'b111;

  typedef enum logic [2:0] {
    EW8, EW16, EW32, EW64, EW128, EW256, EW512, EW1024
  } vew_e;

  typedef enum logic [2:0] {
    LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_RSVD, LMUL_1_8, LMUL_1_4, LMUL_1_2
  } vlmul_e;

  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vew_e   vsew;
    vlmul_e vlmul;
  } vtype_t;

  localparam vtype_t VtypeReset = vtype_t'(9'h100);

  typedef struct packed {
    logic        func1;
    logic [10:0] zimm11;
    logic [4:0]  rs1;
    logic [2:0]  func3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } vsetvli_type_t;

  typedef struct packed {
    logic [1:0] func2;
    logic [9:0] zimm10;
    logic [4:0] uimm5;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } vsetivli_type_t;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } vsetvl_type_t;

  typedef union packed {
    vsetvli_type_t  vsetvli;
    vsetivli_type_t vsetivli;
    vsetvl_type_t   vsetvl;
  } rvv_instruction_t;

  typedef struct packed {
    logic [RvXlen-1:0] result;
    logic              illegal;
  } vcfg_resp_t;

  // VLEN/SEW scaled by LMUL, shifts only.
  function automatic logic [31:0] vlmax(vew_e vsew, vlmul_e vlmul, int unsigned vlen);
    logic [31:0] base;
    base = 32'(vlen) >> (32'd3 + 32'(vsew));
    unique case (vlmul)
      LMUL_1:   vlmax = base;
      LMUL_2:   vlmax = base << 1;
      LMUL_4:   vlmax = base << 2;
      LMUL_8:   vlmax = base << 3;
      LMUL_1_2: vlmax = base >> 1;
      LMUL_1_4: vlmax = base >> 2;
      LMUL_1_8: vlmax = base >> 3;
      default:  vlmax = '0;
    endcase
  endfunction

  function automatic logic vtype_legal(logic [RvXlen-1:0] raw, int unsigned elen);
    logic [31:0] sew;
    logic [31:0] span;
    sew = 32'd8 << raw[5:3];
    unique case (vlmul_e'(raw[2:0]))
      LMUL_1_2: span = sew << 1;
      LMUL_1_4: span = sew << 2;
      LMUL_1_8: span = sew << 3;
      default:  span = sew;
    endcase
    vtype_legal = (raw[RvXlen-1:8] == '0) && (vlmul_e'(raw[2:0]) != LMUL_RSVD) &&
                  (sew <= elen) && (span <= elen);
  endfunction

endpackage

// File: rtl/vcfg_vl_calc.sv
// Combinational new-vl / new-vtype computation for one vset* instruction.
module vcfg_vl_calc import rvv_pkg::*; #(
  parameter int unsigned VLEN = 4096,
  parameter int unsigned ELEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]        avl_i,
  input  logic                   keep_vl_i,
  input  logic [XLEN-1:0]        vtype_raw_i,
  input  logic [$clog2(VLEN):0]  vl_i,
  output logic [$clog2(VLEN):0]  vl_o,
  output vtype_t                 vtype_o,
  output logic                   vill_o
);
  localparam int unsigned VlW = $clog2(VLEN) + 1;

  logic [XLEN-1:0] avl;
  logic [VlW-1:0]  vl_max;

  always_comb begin
    avl    = keep_vl_i ? XLEN'(vl_i) : avl_i;
    vl_max = VlW'(vlmax(vew_e'(vtype_raw_i[5:3]), vlmul_e'(vtype_raw_i[2:0]), VLEN));
    vill_o = !vtype_legal(RvXlen'(vtype_raw_i), ELEN);
    if (vill_o) begin
      vl_o    = '0;
      vtype_o = VtypeReset;
    end else begin
      // Full-width compare so large AVLs saturate instead of wrapping.
      vl_o    = (avl >= XLEN'(vl_max)) ? vl_max : VlW'(avl);
      vtype_o = '{vill: 1'b0, vma: vtype_raw_i[7], vta: vtype_raw_i[6],
                  vsew: vew_e'(vtype_raw_i[5:3]), vlmul: vlmul_e'(vtype_raw_i[2:0])};
    end
  end

endmodule

// File: rtl/vcfg_unit.sv
// RVV configuration unit: two-stage vset* pipeline holding the vl, vtype and vstart CSRs.
module vcfg_unit import rvv_pkg::*; #(
  parameter int unsigned VLEN = 4096,
  parameter int unsigned ELEN = 64,
  parameter int unsigned XLEN = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  rvv_instruction_t         req_instr_i,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [XLEN-1:0]          resp_result_o,
  output logic                     resp_illegal_o,
  output logic                     busy_o,
  output logic [$clog2(VLEN):0]    vl_o,
  output vtype_t                   vtype_o,
  output logic [$clog2(VLEN)-1:0]  vstart_o,
  input  logic                     vstart_we_i,
  input  logic [$clog2(VLEN)-1:0]  vstart_wdata_i
);
  localparam int unsigned VlW = $clog2(VLEN) + 1;
  localparam int unsigned VsW = $clog2(VLEN);

  logic             a_valid_q, a_valid_d;
  rvv_instruction_t a_instr_q, a_instr_d;
  logic [XLEN-1:0]  a_rs1_q, a_rs1_d, a_rs2_q, a_rs2_d;
  logic             b_valid_q, b_valid_d;
  vcfg_resp_t       resp_q, resp_d;
  logic [VlW-1:0]   vl_q, vl_d;
  vtype_t           vtype_q, vtype_d;
  logic [VsW-1:0]   vstart_q, vstart_d;

  logic            is_vset, keep_vl, a_adv, accept, commit, calc_vill;
  logic [XLEN-1:0] avl, vtype_raw;
  logic [VlW-1:0]  calc_vl;
  vtype_t          calc_vtype;

  always_comb begin
    is_vset   = 1'b0;
    keep_vl   = 1'b0;
    avl       = a_rs1_q;
    vtype_raw = '0;
    if (a_instr_q.vsetvl.opcode == OpcodeVec && a_instr_q.vsetvl.func3 == OPCFG) begin
      if (!a_instr_q[31]) begin
        is_vset   = 1'b1;
        vtype_raw = XLEN'(a_instr_q.vsetvli.zimm11);
      end else if (a_instr_q[31:30] == 2'b11) begin
        is_vset   = 1'b1;
        vtype_raw = XLEN'(a_instr_q.vsetivli.zimm10);
      end else if (a_instr_q[31:25] == 7'b1000000) begin
        is_vset   = 1'b1;
        vtype_raw = a_rs2_q;
      end
    end
    if (a_instr_q[31:30] == 2'b11) begin
      avl = XLEN'(a_instr_q.vsetivli.uimm5);
    end else if (a_instr_q.vsetvl.rs1 == 5'd0) begin
      if (a_instr_q.vsetvl.rd != 5'd0) avl = '1;
      else keep_vl = 1'b1;
    end
  end

  // vl_q already holds any commit from the previous cycle, so it doubles as the bypass.
  vcfg_vl_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN),
    .XLEN (XLEN)
  ) u_vl_calc (
    .avl_i       (avl),
    .keep_vl_i   (keep_vl),
    .vtype_raw_i (vtype_raw),
    .vl_i        (vl_q),
    .vl_o        (calc_vl),
    .vtype_o     (calc_vtype),
    .vill_o      (calc_vill)
  );

  always_comb begin
    a_adv       = a_valid_q && (!b_valid_q || resp_ready_i);
    req_ready_o = !a_valid_q || a_adv;
    accept      = req_valid_i && req_ready_o;
    commit      = a_adv && is_vset;

    a_valid_d = accept ? 1'b1 : (a_adv ? 1'b0 : a_valid_q);
    a_instr_d = accept ? req_instr_i : a_instr_q;
    a_rs1_d   = accept ? req_rs1_i : a_rs1_q;
    a_rs2_d   = accept ? req_rs2_i : a_rs2_q;

    b_valid_d = a_adv ? 1'b1 : (resp_ready_i ? 1'b0 : b_valid_q);
    resp_d    = resp_q;
    if (a_adv) begin
      resp_d.result  = (is_vset && !calc_vill) ? RvXlen'(calc_vl) : '0;
      resp_d.illegal = !is_vset;
    end

    vl_d     = commit ? calc_vl : vl_q;
    vtype_d  = commit ? calc_vtype : vtype_q;
    vstart_d = commit ? '0 : (vstart_we_i ? vstart_wdata_i : vstart_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_valid_q <= 1'b0;
      a_instr_q <= '0;
      a_rs1_q   <= '0;
      a_rs2_q   <= '0;
      b_valid_q <= 1'b0;
      resp_q    <= '0;
      vl_q      <= '0;
      vtype_q   <= VtypeReset;
      vstart_q  <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_instr_q <= a_instr_d;
      a_rs1_q   <= a_rs1_d;
      a_rs2_q   <= a_rs2_d;
      b_valid_q <= b_valid_d;
      resp_q    <= resp_d;
      vl_q      <= vl_d;
      vtype_q   <= vtype_d;
      vstart_q  <= vstart_d;
    end
  end

  assign resp_valid_o   = b_valid_q;
  assign resp_result_o  = XLEN'(resp_q.result);
  assign resp_illegal_o = resp_q.illegal;
  assign busy_o         = a_valid_q;
  assign vl_o           = vl_q;
  assign vtype_o        = vtype_q;
  assign vstart_o       = vstart_q;

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed bench for vcfg_unit with hand-computed vl/vtype expectations (VLEN=4096, ELEN=64).
module tb_vcfg_unit;
  localparam int unsigned VLEN = 4096;
  localparam int unsigned ELEN = 64;
  localparam int unsigned XLEN = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_instr = '0;
  logic [63:0] req_rs1 = '0;
  logic [63:0] req_rs2 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_result;
  logic        resp_illegal;
  logic        busy;
  logic [12:0] vl;
  logic [8:0]  vtype;
  logic [11:0] vstart;
  logic        vstart_we = 1'b0;
  logic [11:0] vstart_wdata = '0;

  int errors = 0;
  int checks = 0;

  vcfg_unit #(
    .VLEN (VLEN),
    .ELEN (ELEN),
    .XLEN (XLEN)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_instr_i    (req_instr),
    .req_rs1_i      (req_rs1),
    .req_rs2_i      (req_rs2),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_result_o  (resp_result),
    .resp_illegal_o (resp_illegal),
    .busy_o         (busy),
    .vl_o           (vl),
    .vtype_o        (vtype),
    .vstart_o       (vstart),
    .vstart_we_i    (vstart_we),
    .vstart_wdata_i (vstart_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_vsetvli(input logic [4:0] rd, input logic [4:0] rs1,
                                              input logic [10:0] zimm);
    return {1'b0, zimm, rs1, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetivli(input logic [4:0] rd, input logic [4:0] uimm,
                                               input logic [9:0] zimm);
    return {2'b11, zimm, uimm, 3'b111, rd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vsetvl(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
    return {7'b1000000, rs2, rs1, 3'b111, rd, 7'h57};
  endfunction

  // Single isolated transaction: accept, busy for one cycle, response two cycles after request.
  task automatic run_vset(input string tag, input logic [31:0] instr, input logic [63:0] rs1,
                          input logic [63:0] rs2, input logic [63:0] exp_res,
                          input logic exp_ill, input logic [8:0] exp_vtype,
                          input logic [12:0] exp_vl);
    req_valid = 1'b1;
    req_instr = instr;
    req_rs1   = rs1;
    req_rs2   = rs2;
    #1;
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_early"}, 64'(resp_valid), 64'd0);
    step();
    check_eq({tag, "_valid"}, 64'(resp_valid), 64'd1);
    check_eq({tag, "_result"}, resp_result, exp_res);
    check_eq({tag, "_illegal"}, 64'(resp_illegal), 64'(exp_ill));
    check_eq({tag, "_vl"}, 64'(vl), 64'(exp_vl));
    check_eq({tag, "_vtype"}, 64'(vtype), 64'(exp_vtype));
    step();
    check_eq({tag, "_drain"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin : main
    #12;
    check_eq("rst_vtype", 64'(vtype), 64'h100);
    check_eq("rst_vl", 64'(vl), 64'd0);
    check_eq("rst_vstart", 64'(vstart), 64'd0);
    check_eq("rst_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_result", resp_result, 64'd0);
    check_eq("rst_illegal", 64'(resp_illegal), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    run_vset("t1", enc_vsetvli(5'd5, 5'd6, 11'h010), 64'd1000, 64'd0, 64'd128, 1'b0, 9'h010,
             13'd128);
    run_vset("t2a", enc_vsetvli(5'd5, 5'd0, 11'h003), 64'd77, 64'd0, 64'd4096, 1'b0, 9'h003,
             13'd4096);
    run_vset("t2b", enc_vsetivli(5'd5, 5'd17, 10'h01F), 64'd0, 64'd0, 64'd0, 1'b0, 9'h100,
             13'd0);
    run_vset("t3a", enc_vsetvl(5'd5, 5'd6, 5'd7), 64'd50, 64'h100, 64'd0, 1'b0, 9'h100, 13'd0);
    run_vset("t3b", enc_vsetvl(5'd0, 5'd0, 5'd7), 64'd50, 64'h009, 64'd0, 1'b0, 9'h009, 13'd0);
    run_vset("avl_hi", enc_vsetvli(5'd5, 5'd6, 11'h000), 64'h1_0000_0005, 64'd0, 64'd512,
             1'b0, 9'h000, 13'd512);

    // Back-to-back: second (rs1=rd=x0, e32 m2) must see vl=128 from the first, not 512.
    req_valid = 1'b1;
    req_instr = enc_vsetvli(5'd5, 5'd6, 11'h010);
    req_rs1   = 64'd1000;
    step();
    req_instr = enc_vsetvli(5'd0, 5'd0, 11'h011);
    #1;
    check_eq("b2b_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check_eq("b2b_first", resp_result, 64'd128);
    step();
    check_eq("b2b_second", resp_result, 64'd128);
    check_eq("b2b_vtype", 64'(vtype), 64'h011);
    step();

    // vstart write alone, then write colliding with a commit.
    vstart_we    = 1'b1;
    vstart_wdata = 12'd7;
    step();
    vstart_we = 1'b0;
    check_eq("t4_vstart_wr", 64'(vstart), 64'd7);
    req_valid = 1'b1;
    req_instr = enc_vsetivli(5'd5, 5'd3, 10'h000);
    step();
    req_valid    = 1'b0;
    vstart_we    = 1'b1;
    vstart_wdata = 12'd9;
    step();
    vstart_we = 1'b0;
    check_eq("t4_vstart_clr", 64'(vstart), 64'd0);
    check_eq("t4_result", resp_result, 64'd3);
    step();

    // Three back-to-back vsetivli with the response side stalled.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_instr  = enc_vsetivli(5'd5, 5'd5, 10'h000);
    step();
    req_instr = enc_vsetivli(5'd5, 5'd10, 10'h000);
    #1;
    check_eq("t5_ready2", 64'(req_ready), 64'd1);
    step();
    req_instr = enc_vsetivli(5'd5, 5'd31, 10'h000);
    #1;
    check_eq("t5_ready3", 64'(req_ready), 64'd0);
    check_eq("t5_vl_hold", 64'(vl), 64'd5);
    for (int k = 0; k < 3; k++) begin
      check_eq("t5_hold_valid", 64'(resp_valid), 64'd1);
      check_eq("t5_hold_result", resp_result, 64'd5);
      check_eq("t5_hold_busy", 64'(busy), 64'd1);
      step();
    end
    resp_ready = 1'b1;
    #1;
    check_eq("t5_ready3_go", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
    check_eq("t5_resp2", resp_result, 64'd10);
    check_eq("t5_vl2", 64'(vl), 64'd10);
    step();
    check_eq("t5_resp3", resp_result, 64'd31);
    check_eq("t5_vl3", 64'(vl), 64'd31);
    step();
    check_eq("t5_drain", 64'(resp_valid), 64'd0);

    // Non-vset instructions leave the CSRs alone.
    run_vset("t6_opivv", {1'b0, 11'h010, 5'd6, 3'b000, 5'd5, 7'h57}, 64'd1000, 64'd0, 64'd0,
             1'b1, 9'h000, 13'd31);
    run_vset("t6_func7", {7'b1000001, 5'd7, 5'd6, 3'b111, 5'd5, 7'h57}, 64'd1000, 64'h010,
             64'd0, 1'b1, 9'h000, 13'd31);

    // Reset with two entries in flight.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_instr  = enc_vsetivli(5'd5, 5'd4, 10'h010);
    step();
    req_instr = enc_vsetivli(5'd5, 5'd6, 10'h010);
    step();
    req_valid = 1'b0;
    check_eq("rst_inflight_busy", 64'(busy), 64'd1);
    check_eq("rst_inflight_valid", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    check_eq("rst_mid_vtype", 64'(vtype), 64'h100);
    check_eq("rst_mid_vl", 64'(vl), 64'd0);
    step();
    rst        = 1'b0;
    resp_ready = 1'b1;
    step();
    check_eq("rst_after_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_after_vtype", 64'(vtype), 64'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
